writeback_regfile: RTL and testbench

- Final pipeline stage, directly downstream of the memory stage. Consumes that stage's registered outputs: bubble, pc, insn, write request, write number and write data.
- Commits register writes into the architectural 16x32 register file, which lives in this block.
- Serves combinational read ports to the decode stage and to the memory stage's store-data port.
- A write to r15 is turned into a registered jump request. Younger wrong-path instructions already in flight are squashed for a fixed number of committing slots.

---
 rtl/writeback_regfile.sv | 119 +++++++++++
 tb/tb_writeback_regfile.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/writeback_regfile.sv
// Writeback stage: commits register writes into the 16x32 architectural file,
// turns r15 writes into a registered jump and squashes the wrong-path slots behind it.

module writeback_rd_port (
  input  logic [3:0]        num,
  input  logic [31:0]       r15_val,
  input  logic [14:0][31:0] regs,
  input  logic              byp_en,
  input  logic [3:0]        byp_num,
  input  logic [31:0]       byp_data,
  output logic [31:0]       data
);
  always_comb begin
    data = r15_val;
    if (num != 4'd15) begin
      data = '0;
      for (int i = 0; i < 15; i++)
        if (num == 4'(i)) data = regs[i];
      // Same-cycle commit wins over the stale storage value.
      if (byp_en && byp_num == num) data = byp_data;
    end
  end
endmodule

module writeback_regfile #(
  parameter int FLUSH_DEPTH = 2,
  parameter int PC_READ_OFS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inbubble,
  input  logic [31:0] pc,
  input  logic [31:0] insn,
  input  logic        write_reg,
  input  logic [3:0]  write_num,
  input  logic [31:0] write_data,
  input  logic [3:0]  rf_rd0_num,
  input  logic [3:0]  rf_rd1_num,
  input  logic [3:0]  rf_rd2_num,
  input  logic [31:0] rd_pc,
  output logic [31:0] rf_rd0_data,
  output logic [31:0] rf_rd1_data,
  output logic [31:0] rf_rd2_data,
  input  logic [3:0]  st_read,
  output logic [31:0] st_data,
  output logic        outjmp,
  output logic [31:0] outjmppc,
  output logic [31:0] retired,
  output logic        squashing
);
  localparam int SQW    = (FLUSH_DEPTH < 1) ? 1 : $clog2(FLUSH_DEPTH + 1);
  localparam int NUM_RD = 4;

  logic [14:0][31:0] regs;
  logic [SQW-1:0]    sq;
  logic              valid, commit, commit_rf, commit_jmp;

  // insn only travels with the slot for trace purposes.
  logic unused_insn;
  assign unused_insn = ^insn;

  assign valid      = !inbubble;
  assign squashing  = (sq != '0);
  assign commit     = valid && !squashing && write_reg;
  assign commit_rf  = commit && (write_num != 4'd15);
  assign commit_jmp = commit && (write_num == 4'd15);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < 15; i++)
        if (commit_rf && write_num == 4'(i)) regs[i] <= write_data;
    end
  end

  // A committed r15 write reloads the window; squashed slots only count it down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq       <= '0;
      outjmp   <= 1'b0;
      outjmppc <= '0;
      retired  <= '0;
    end else begin
      outjmp <= commit_jmp;
      if (commit_jmp) begin
        outjmppc <= {write_data[31:2], 2'b00};
        sq       <= SQW'(FLUSH_DEPTH);
      end else if (valid && squashing) begin
        sq <= sq - SQW'(1);
      end
      if (valid && !squashing) retired <= retired + 32'd1;
    end
  end

  logic [NUM_RD-1:0][3:0]  rd_num;
  logic [NUM_RD-1:0][31:0] rd_r15;
  logic [NUM_RD-1:0][31:0] rd_data;

  assign rd_num = {st_read, rf_rd2_num, rf_rd1_num, rf_rd0_num};
  assign rd_r15 = {pc + 32'd12, {3{rd_pc + 32'(PC_READ_OFS)}}};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    writeback_rd_port u_port (
      .num      (rd_num[p]),
      .r15_val  (rd_r15[p]),
      .regs     (regs),
      .byp_en   (commit_rf),
      .byp_num  (write_num),
      .byp_data (write_data),
      .data     (rd_data[p])
    );
  end

  assign rf_rd0_data = rd_data[0];
  assign rf_rd1_data = rd_data[1];
  assign rf_rd2_data = rd_data[2];
  assign st_data     = rd_data[3];
endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: architectural model checked every cycle,
// plus literal expectations along the directed sequence.

module tb_writeback_regfile;
  localparam int FLUSH = 2;

  logic        clk = 0, rst = 1;
  logic        inbubble = 1, write_reg = 0;
  logic [31:0] pc = 0, insn = 0, write_data = 0, rd_pc = 0;
  logic [3:0]  write_num = 0, rf_rd0_num = 0, rf_rd1_num = 0, rf_rd2_num = 0, st_read = 0;
  logic [31:0] rf_rd0_data, rf_rd1_data, rf_rd2_data, st_data, outjmppc, retired;
  logic        outjmp, squashing;

  int n_chk = 0, n_fail = 0;

  writeback_regfile #(.FLUSH_DEPTH(FLUSH), .PC_READ_OFS(8)) dut (
    .clk(clk), .rst(rst), .inbubble(inbubble), .pc(pc), .insn(insn),
    .write_reg(write_reg), .write_num(write_num), .write_data(write_data),
    .rf_rd0_num(rf_rd0_num), .rf_rd1_num(rf_rd1_num), .rf_rd2_num(rf_rd2_num),
    .rd_pc(rd_pc), .rf_rd0_data(rf_rd0_data), .rf_rd1_data(rf_rd1_data),
    .rf_rd2_data(rf_rd2_data), .st_read(st_read), .st_data(st_data),
    .outjmp(outjmp), .outjmppc(outjmppc), .retired(retired), .squashing(squashing)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: register array, slots left to squash, retire count, jump.
  logic [31:0] m_rf [15];
  int          m_sq;
  logic [31:0] m_ret, m_jpc;
  logic        m_jmp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) m_rf[i] <= 0;
      m_sq <= 0; m_ret <= 0; m_jmp <= 0; m_jpc <= 0;
    end else begin
      m_jmp <= 0;
      if (!inbubble) begin
        if (m_sq > 0) m_sq <= m_sq - 1;
        else begin
          m_ret <= m_ret + 1;
          if (write_reg) begin
            if (write_num == 15) begin
              m_jmp <= 1; m_jpc <= write_data & 32'hFFFF_FFFC; m_sq <= FLUSH;
            end else m_rf[write_num] <= write_data;
          end
        end
      end
    end
  end

  function automatic logic [31:0] exp_rd(input logic [3:0] n, input logic [31:0] r15v);
    if (n == 15) return r15v;
    if (!inbubble && m_sq == 0 && write_reg && write_num == n) return write_data;
    return m_rf[n];
  endfunction

  always @(negedge clk) begin
    chk("m_rd0", rf_rd0_data, exp_rd(rf_rd0_num, rd_pc + 8));
    chk("m_rd1", rf_rd1_data, exp_rd(rf_rd1_num, rd_pc + 8));
    chk("m_rd2", rf_rd2_data, exp_rd(rf_rd2_num, rd_pc + 8));
    chk("m_st", st_data, exp_rd(st_read, pc + 12));
    chk("m_jmp", 32'(outjmp), 32'(m_jmp));
    chk("m_jpc", outjmppc, m_jpc);
    chk("m_ret", retired, m_ret);
    chk("m_sq", 32'(squashing), 32'(m_sq != 0));
  end

  task automatic drive(input logic b, input logic w, input logic [3:0] n, input logic [31:0] d);
    @(posedge clk); #1;
    inbubble = b; write_reg = w; write_num = n; write_data = d;
    pc = pc + 4; insn = {28'h0, n};
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 chk("rst_ret", retired, 0);
    chk("rst_jmp", 32'(outjmp), 0);
    chk("rst_sq", 32'(squashing), 0);
    rst = 0;
    drive(1, 0, 0, 0);
    for (int n = 0; n < 15; n++) begin
      rf_rd0_num = 4'(n); rf_rd1_num = 4'(n); rf_rd2_num = 4'(n); st_read = 4'(n);
      #1;
      chk("rst_rd0", rf_rd0_data, 0); chk("rst_rd1", rf_rd1_data, 0);
      chk("rst_rd2", rf_rd2_data, 0); chk("rst_st", st_data, 0);
    end
    rd_pc = 32'h100; rf_rd0_num = 15; #1 chk("r15_rd", rf_rd0_data, 32'h108);
    pc = 32'h1FC; drive(1, 0, 0, 0);   // pc advances to 0x200
    st_read = 15; #1 chk("r15_st", st_data, 32'h20C);

    rf_rd1_num = 3;
    drive(0, 1, 3, 32'hDEADBEEF);
    chk("byp_r3", rf_rd1_data, 32'hDEADBEEF); chk("ret0", retired, 0);
    drive(0, 0, 3, 0);
    chk("stor_r3", rf_rd1_data, 32'hDEADBEEF); chk("ret1", retired, 1);

    drive(0, 1, 15, 32'h1003);
    chk("nojmp_yet", 32'(outjmp), 0);
    drive(0, 1, 1, 1);
    chk("jmp", 32'(outjmp), 1); chk("jpc", outjmppc, 32'h1000); chk("sq1", 32'(squashing), 1);
    drive(0, 1, 2, 2);
    chk("jmp_once", 32'(outjmp), 0); chk("sq2", 32'(squashing), 1);
    drive(0, 1, 4, 4);
    chk("sq_done", 32'(squashing), 0); chk("ret3", retired, 3);
    rf_rd0_num = 1; rf_rd1_num = 2; rf_rd2_num = 4;
    drive(1, 0, 0, 0);
    chk("r1_sq", rf_rd0_data, 0); chk("r2_sq", rf_rd1_data, 0); chk("r4", rf_rd2_data, 4);
    chk("ret4", retired, 4);

    rf_rd0_num = 5;
    drive(0, 1, 15, 32'h2000);
    drive(1, 1, 5, 5);
    chk("jmp2", 32'(outjmp), 1); chk("jpc2", outjmppc, 32'h2000); chk("sq_bub", 32'(squashing), 1);
    drive(0, 1, 5, 5);
    chk("no_byp_sq", rf_rd0_data, 0); chk("sq_v1", 32'(squashing), 1);
    drive(1, 1, 5, 5);
    chk("sq_bub2", 32'(squashing), 1);
    drive(0, 1, 15, 32'h3000);
    chk("sq_r15", 32'(squashing), 1);
    drive(1, 1, 5, 5);
    chk("no_jmp_sq", 32'(outjmp), 0); chk("sq_end", 32'(squashing), 0);
    chk("r5_bub", rf_rd0_data, 0); chk("ret5", retired, 5);
    drive(0, 0, 0, 0);
    drive(0, 1, 15, 32'h4000);
    drive(0, 1, 8, 8);
    chk("ret7", retired, 7); chk("sq_pre", 32'(squashing), 1);
    #2 rst = 1;
    #1 chk("arst_ret", retired, 0); chk("arst_sq", 32'(squashing), 0);
    chk("arst_jmp", 32'(outjmp), 0);
    inbubble = 1;
    @(posedge clk); #1 rst = 0;
    rf_rd2_num = 6; rf_rd1_num = 3;
    drive(0, 1, 6, 6);
    chk("r6_byp", rf_rd2_data, 6); chk("r3_rst", rf_rd1_data, 0);
    drive(1, 0, 0, 0);
    chk("r6", rf_rd2_data, 6); chk("ret_post", retired, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
